// File: rtl/axi_read_burst_splitter.sv
// Splits one long upstream read request into INCR bursts that respect the maximum
// burst length and never cross a 4 KB page; read data passes straight through.
module axi_read_burst_splitter #(
    parameter int AXI_AWIDTH        = 32,
    parameter int AXI_DWIDTH        = 32,
    parameter int AXI_MAX_BURST_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_read_request_valid,
    output logic                  in_read_request_ready,
    input  logic [AXI_AWIDTH-1:0] in_read_addr,
    input  logic [31:0]           in_read_len,
    input  logic [2:0]            in_read_size,
    input  logic [1:0]            in_read_burst,
    output logic [AXI_DWIDTH-1:0] in_read_data,
    output logic                  in_read_data_valid,
    input  logic                  in_read_data_ready,
    output logic                  in_read_data_last,
    output logic                  out_read_request_valid,
    input  logic                  out_read_request_ready,
    output logic [AXI_AWIDTH-1:0] out_read_addr,
    output logic [31:0]           out_read_len,
    output logic [2:0]            out_read_size,
    output logic [1:0]            out_read_burst,
    input  logic [AXI_DWIDTH-1:0] out_read_data,
    input  logic                  out_read_data_valid,
    output logic                  out_read_data_ready
);
    localparam int BSHIFT = $clog2(AXI_DWIDTH / 8);
    localparam logic [AXI_AWIDTH-1:0] ALIGN_MASK =
        ~((AXI_AWIDTH'(1) << BSHIFT) - AXI_AWIDTH'(1));

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [AXI_AWIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [32:0]           remaining_q, remaining_d;
    logic [32:0]           issue_cnt_q, issue_cnt_d;
    logic [32:0]           data_cnt_q, data_cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    logic                  busy;
    logic                  beat_hs;
    logic [8:0]            chunk;
    logic [AXI_AWIDTH-1:0] next_addr;
    logic [32:0]           next_rem;

    // Burst length (beats minus 1) limited by remaining beats, burst cap and page end.
    function automatic logic [7:0] chunk_len(input logic [11:0] page_off,
                                             input logic [32:0] rem);
        logic [12:0] page_beats;
        logic [32:0] c;
        page_beats = (13'd4096 - {1'b0, page_off}) >> BSHIFT;
        c = rem;
        if (c > 33'(AXI_MAX_BURST_LEN)) c = 33'(AXI_MAX_BURST_LEN);
        if (c > 33'(page_beats))        c = 33'(page_beats);
        return 8'(c - 33'd1);
    endfunction

    assign busy                   = (state_q != IDLE);
    assign in_read_request_ready  = (state_q == IDLE);
    assign out_read_request_valid = (state_q == ISSUE);
    assign out_read_addr          = addr_q;
    assign out_read_len           = {24'd0, len_q};
    assign out_read_size          = size_q;
    assign out_read_burst         = burst_q;

    assign in_read_data        = out_read_data;
    assign in_read_data_valid  = out_read_data_valid & busy;
    assign out_read_data_ready = in_read_data_ready & busy;
    assign in_read_data_last   = in_read_data_valid & (data_cnt_q == issue_cnt_q - 33'd1);
    assign beat_hs             = in_read_data_valid & in_read_data_ready;

    assign chunk     = {1'b0, len_q} + 9'd1;
    assign next_addr = addr_q + (AXI_AWIDTH'(chunk) << BSHIFT);
    assign next_rem  = remaining_q - 33'(chunk);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        issue_cnt_d = issue_cnt_q;
        data_cnt_d  = data_cnt_q;
        size_d      = size_q;
        burst_d     = burst_q;
        case (state_q)
            IDLE: begin
                if (in_read_request_valid) begin
                    addr_d      = in_read_addr & ALIGN_MASK;
                    remaining_d = {1'b0, in_read_len} + 33'd1;
                    issue_cnt_d = {1'b0, in_read_len} + 33'd1;
                    data_cnt_d  = 33'd0;
                    len_d       = chunk_len(addr_d[11:0], remaining_d);
                    size_d      = in_read_size;
                    burst_d     = in_read_burst;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (out_read_request_ready) begin
                    addr_d      = next_addr;
                    remaining_d = next_rem;
                    if (next_rem == 33'd0) begin
                        state_d = DRAIN;
                    end else begin
                        len_d = chunk_len(next_addr[11:0], next_rem);
                    end
                end
            end
            DRAIN: begin
            end
            default: state_d = IDLE;
        endcase
        // Completion of the whole request takes priority over any pending issue.
        if (beat_hs) begin
            data_cnt_d = data_cnt_q + 33'd1;
            if (in_read_data_last) state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            issue_cnt_q <= '0;
            data_cnt_q  <= '0;
            size_q      <= '0;
            burst_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            issue_cnt_q <= issue_cnt_d;
            data_cnt_q  <= data_cnt_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
        end
    end
endmodule

// File: tb/tb_axi_read_burst_splitter.sv
// Randomized bench: a behavioural model derives the expected burst sequence from
// address/length arithmetic and an adapter model returns beats for accepted bursts.
module tb_axi_read_burst_splitter;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_read_request_valid;
    logic        in_read_request_ready;
    logic [31:0] in_read_addr;
    logic [31:0] in_read_len;
    logic [2:0]  in_read_size;
    logic [1:0]  in_read_burst;
    logic [31:0] in_read_data;
    logic        in_read_data_valid;
    logic        in_read_data_ready;
    logic        in_read_data_last;
    logic        out_read_request_valid;
    logic        out_read_request_ready;
    logic [31:0] out_read_addr;
    logic [31:0] out_read_len;
    logic [2:0]  out_read_size;
    logic [1:0]  out_read_burst;
    logic [31:0] out_read_data;
    logic        out_read_data_valid;
    logic        out_read_data_ready;

    always #5 clk = ~clk;

    axi_read_burst_splitter #(
        .AXI_AWIDTH(32), .AXI_DWIDTH(32), .AXI_MAX_BURST_LEN(256)
    ) dut (
        .clk(clk), .rst(rst),
        .in_read_request_valid(in_read_request_valid),
        .in_read_request_ready(in_read_request_ready),
        .in_read_addr(in_read_addr), .in_read_len(in_read_len),
        .in_read_size(in_read_size), .in_read_burst(in_read_burst),
        .in_read_data(in_read_data), .in_read_data_valid(in_read_data_valid),
        .in_read_data_ready(in_read_data_ready), .in_read_data_last(in_read_data_last),
        .out_read_request_valid(out_read_request_valid),
        .out_read_request_ready(out_read_request_ready),
        .out_read_addr(out_read_addr), .out_read_len(out_read_len),
        .out_read_size(out_read_size), .out_read_burst(out_read_burst),
        .out_read_data(out_read_data), .out_read_data_valid(out_read_data_valid),
        .out_read_data_ready(out_read_data_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit              m_busy;
    longint unsigned m_addr, m_rem, m_total, m_done;
    int              m_pend;
    bit              req_pending;
    logic [31:0]     req_addr, req_len;
    int              rr_mode, dr_mode, dv_pct;
    int              bursts_seen, stall_cnt;
    bit              prev_stall;
    logic [31:0]     prev_addr, prev_len;

    function automatic longint unsigned chunk_of(longint unsigned a, longint unsigned rem);
        longint unsigned page, c;
        page = (64'd4096 - (a % 64'd4096)) / 64'd4;
        c = rem;
        if (c > 64'd256) c = 64'd256;
        if (c > page) c = page;
        return c;
    endfunction

    // One clock: drive at negedge, sample 1 time unit later, update the model.
    task automatic step();
        bit busy_now;
        longint unsigned c;
        @(negedge clk);
        busy_now = m_busy;
        in_read_request_valid = req_pending;
        in_read_addr  = req_addr;
        in_read_len   = req_len;
        in_read_size  = 3'd2;
        in_read_burst = 2'b01;
        case (rr_mode)
            0: out_read_request_ready = 1'b1;
            1: out_read_request_ready = 1'($urandom_range(0, 1));
            default: begin
                if (bursts_seen == 1 && stall_cnt < 5) begin
                    out_read_request_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    out_read_request_ready = 1'b1;
                end
            end
        endcase
        case (dr_mode)
            0: in_read_data_ready = 1'b1;
            1: in_read_data_ready = 1'($urandom_range(0, 1));
            default: in_read_data_ready = ~in_read_data_ready;
        endcase
        out_read_data_valid = (m_pend > 0) && ($urandom_range(0, 99) < dv_pct);
        out_read_data = $urandom;
        #1;
        check("up_ready", in_read_request_ready, !busy_now);
        check("req_valid", out_read_request_valid, busy_now && m_rem != 0);
        if (prev_stall) begin
            check("stall_addr", out_read_addr, prev_addr);
            check("stall_len", out_read_len, prev_len);
        end
        if (out_read_request_valid && out_read_request_ready && busy_now && m_rem != 0) begin
            c = chunk_of(m_addr, m_rem);
            check("burst_addr", out_read_addr, m_addr);
            check("burst_len", out_read_len, c - 1);
            check("burst_size", out_read_size, 3'd2);
            check("burst_type", out_read_burst, 2'b01);
            m_addr = (m_addr + 4 * c) & 64'hFFFF_FFFF;
            m_rem -= c;
            m_pend += int'(c);
            bursts_seen++;
        end
        prev_stall = out_read_request_valid && !out_read_request_ready;
        prev_addr  = out_read_addr;
        prev_len   = out_read_len;
        check("rd_valid", in_read_data_valid, out_read_data_valid && busy_now);
        check("rd_ready", out_read_data_ready, in_read_data_ready && busy_now);
        if (in_read_data_valid) begin
            check("rd_data", in_read_data, out_read_data);
            check("rd_last", in_read_data_last, m_done + 1 == m_total);
        end else begin
            check("rd_last_idle", in_read_data_last, 1'b0);
        end
        if (out_read_data_valid && in_read_data_ready && busy_now) begin
            m_done++;
            m_pend--;
            if (m_done == m_total) m_busy = 1'b0;
        end
        if (req_pending && in_read_request_ready && !busy_now) begin
            req_pending = 1'b0;
            m_busy      = 1'b1;
            m_addr      = longint'(req_addr & 32'hFFFF_FFFC);
            m_rem       = longint'(req_len) + 1;
            m_total     = m_rem;
            m_done      = 0;
            bursts_seen = 0;
            stall_cnt   = 0;
        end
    endtask

    task automatic run_req(input logic [31:0] addr, input logic [31:0] len,
                           input int rr, input int dr, input int dv);
        int n;
        int budget;
        req_addr = addr;
        req_len = len;
        req_pending = 1'b1;
        rr_mode = rr;
        dr_mode = dr;
        dv_pct = dv;
        budget = (int'(len) + 1) * 20 + 200;
        n = 0;
        do begin
            step();
            n++;
        end while ((req_pending || m_busy) && n < budget);
        check("req_timeout", req_pending || m_busy, 1'b0);
        check("beats_left", m_pend, 0);
        $display("[TB] req addr=0x%08h len=%0d bursts=%0d beats=%0d cycles=%0d",
                 addr, len, bursts_seen, m_done, n);
    endtask

    task automatic reset_mid(input logic [31:0] addr, input logic [31:0] len, input int nb);
        int n;
        req_addr = addr;
        req_len = len;
        req_pending = 1'b1;
        rr_mode = 0;
        dr_mode = 1;
        dv_pct = 80;
        n = 0;
        do begin
            step();
            n++;
        end while ((req_pending || bursts_seen < nb) && n < 2000);
        check("rst_setup_timeout", req_pending || bursts_seen < nb, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_read_request_valid = 1'b0;
        out_read_request_ready = 1'b1;
        out_read_data_valid = 1'b1;
        in_read_data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_up_ready", in_read_request_ready, 1'b1);
        check("rst_req_valid", out_read_request_valid, 1'b0);
        check("rst_rd_valid", in_read_data_valid, 1'b0);
        check("rst_rd_ready", out_read_data_ready, 1'b0);
        check("rst_rd_last", in_read_data_last, 1'b0);
        check("rst_addr", out_read_addr, 32'h0);
        check("rst_len", out_read_len, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        out_read_data_valid = 1'b0;
        m_busy = 1'b0;
        m_pend = 0;
        m_rem = 0;
        req_pending = 1'b0;
        prev_stall = 1'b0;
        $display("[TB] reset mid-request addr=0x%08h len=0x%08h after %0d bursts", addr, len, nb);
    endtask

    initial begin
        logic [31:0] ra;
        rst = 1'b1;
        in_read_request_valid = 1'b0;
        in_read_addr = '0;
        in_read_len = '0;
        in_read_size = 3'd2;
        in_read_burst = 2'b01;
        in_read_data_ready = 1'b0;
        out_read_request_ready = 1'b0;
        out_read_data = '0;
        out_read_data_valid = 1'b0;
        m_busy = 1'b0; m_pend = 0; m_rem = 0; m_done = 0; m_total = 0; m_addr = 0;
        req_pending = 1'b0; prev_stall = 1'b0; bursts_seen = 0; stall_cnt = 0;
        rr_mode = 0; dr_mode = 0; dv_pct = 100;
        req_addr = '0; req_len = '0; prev_addr = '0; prev_len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_up_ready", in_read_request_ready, 1'b1);
        check("reset_req_valid", out_read_request_valid, 1'b0);
        check("reset_rd_valid", in_read_data_valid, 1'b0);
        check("reset_rd_ready", out_read_data_ready, 1'b0);
        check("reset_rd_last", in_read_data_last, 1'b0);
        check("reset_addr", out_read_addr, 32'h0);
        check("reset_len", out_read_len, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_req(32'h0000_1000, 32'd3,   0, 0, 100);
        run_req(32'h0000_0000, 32'd599, 0, 0, 100);
        run_req(32'h0000_0FF0, 32'd7,   0, 0, 100);
        run_req(32'h0000_0000, 32'd599, 2, 2, 75);
        run_req(32'h0000_0FF6, 32'd5,   1, 1, 60);
        run_req(32'hFFFF_FFF0, 32'd7,   1, 1, 60);
        run_req(32'h0000_3000, 32'd1023, 1, 0, 90);

        reset_mid(32'h0000_0000, 32'd599, 1);
        run_req(32'h0000_2000, 32'd0, 0, 0, 100);
        reset_mid(32'h0000_0000, 32'hFFFF_FFFF, 3);
        run_req(32'h0000_0400, 32'd0, 1, 1, 50);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            if (i % 2 == 1) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            run_req(ra, 32'($urandom_range(0, 300)), 1, 1, 70);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
